fifo_frame_reader: RTL and testbench



---
 rtl/fifo_frame_reader_if.sv | 53 +++++
 rtl/fifo_frame_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_frame_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_frame_reader_if.sv
// Bundle of the FIFO read port, the FFT sink stream and the frame control
// strobes used by fifo_frame_reader. The master view is the reader itself;
// the slave view is whatever sits around it (FIFO, FFT core, sequencer).
interface fifo_frame_reader_if #(
  parameter int DATA_W  = 12,
  parameter int USEDW_W = 11
);
  logic               frame_req;
  logic [USEDW_W-1:0] fifo_rdusedw;
  logic               fifo_rdfull;
  logic               fifo_rdempty;
  logic [DATA_W-1:0]  fifo_q;
  logic               fifo_rdreq;
  logic               sink_ready;
  logic               sink_valid;
  logic               sink_sop;
  logic               sink_eop;
  logic [DATA_W-1:0]  sink_data;
  logic               busy;
  logic               frame_done;

  modport master (
    input  frame_req,
    input  fifo_rdusedw,
    input  fifo_rdfull,
    input  fifo_rdempty,
    input  fifo_q,
    output fifo_rdreq,
    input  sink_ready,
    output sink_valid,
    output sink_sop,
    output sink_eop,
    output sink_data,
    output busy,
    output frame_done
  );

  modport slave (
    output frame_req,
    output fifo_rdusedw,
    output fifo_rdfull,
    output fifo_rdempty,
    output fifo_q,
    input  fifo_rdreq,
    output sink_ready,
    input  sink_valid,
    input  sink_sop,
    input  sink_eop,
    input  sink_data,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Read-side frame controller for the sample FIFO. Waits until one full frame
// is buffered, then drains exactly FRAME_LEN samples into the FFT sink as a
// single sop..eop stream. The FIFO has one cycle of read latency, so returned
// words land in a two-entry skid buffer whose head drives the sink outputs;
// this keeps one beat per cycle when the sink is ready and loses nothing when
// it stalls.
module fifo_frame_reader #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 1024,
  parameter int USEDW_W   = 11,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_frame_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FILL,
    STREAM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              rd_inflight;
  logic [DATA_W-1:0] buf1_data;
  logic              buf1_valid;

  logic              fill_ok;
  logic              accept;
  logic [1:0]        occupancy;
  logic              rd_issue;
  logic [CNT_W-1:0]  next_idx;

  // The rdfull term covers a usedw counter that wraps to zero at full depth.
  assign fill_ok = bus.fifo_rdfull || (32'(bus.fifo_rdusedw) >= 32'(FRAME_LEN));

  assign accept = bus.sink_valid && bus.sink_ready;

  // Entries that will still be held or arriving after this cycle's pop; a new
  // read is only allowed if the skid buffer is guaranteed a free slot for it.
  assign occupancy = 2'(bus.sink_valid) + 2'(buf1_valid) + 2'(rd_inflight) - 2'(accept);

  // The read strobe is decoded from registered state plus the live empty flag
  // so that a read is never issued against an empty FIFO.
  assign rd_issue = (state == STREAM) && (rd_cnt < LEN_CNT) &&
                    !bus.fifo_rdempty && (occupancy < 2'd2);

  assign bus.fifo_rdreq = rd_issue;

  // Frame index of the beat that will sit at the head next cycle.
  assign next_idx = accept ? out_cnt + CNT_W'(1) : out_cnt;

  // Frame sequencing, read/accept counters and the skid buffer in one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_cnt         <= '0;
      out_cnt        <= '0;
      rd_inflight    <= 1'b0;
      buf1_data      <= '0;
      buf1_valid     <= 1'b0;
      bus.sink_valid <= 1'b0;
      bus.sink_sop   <= 1'b0;
      bus.sink_eop   <= 1'b0;
      bus.sink_data  <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      case (state)
        IDLE: begin
          bus.frame_done <= 1'b0;
          if (bus.frame_req) begin
            state    <= WAIT_FILL;
            bus.busy <= 1'b1;
            rd_cnt   <= '0;
            out_cnt  <= '0;
          end
        end

        WAIT_FILL: begin
          if (fill_ok) begin
            state <= STREAM;
          end
        end

        STREAM: begin
          if (rd_issue) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
          if (accept) begin
            out_cnt <= out_cnt + CNT_W'(1);
          end
          if (!bus.sink_valid || accept) begin
            if (buf1_valid) begin
              bus.sink_data  <= buf1_data;
              bus.sink_valid <= 1'b1;
              bus.sink_sop   <= (next_idx == '0);
              bus.sink_eop   <= (next_idx == LAST_IDX);
              buf1_valid     <= rd_inflight;
              if (rd_inflight) begin
                buf1_data <= bus.fifo_q;
              end
            end else if (rd_inflight) begin
              bus.sink_data  <= bus.fifo_q;
              bus.sink_valid <= 1'b1;
              bus.sink_sop   <= (next_idx == '0);
              bus.sink_eop   <= (next_idx == LAST_IDX);
            end else begin
              bus.sink_valid <= 1'b0;
              bus.sink_sop   <= 1'b0;
              bus.sink_eop   <= 1'b0;
            end
          end else if (rd_inflight) begin
            buf1_data  <= bus.fifo_q;
            buf1_valid <= 1'b1;
          end
          if (accept && bus.sink_eop) begin
            state          <= DONE;
            bus.frame_done <= 1'b1;
          end
        end

        DONE: begin
          bus.frame_done <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with an 8-sample frame. A small FIFO
// model feeds the read port with one cycle of latency; a negedge monitor logs
// every accepted beat, output stability under stall and outstanding reads.
module tb_fifo_frame_reader;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 8;
  localparam int USEDW_W   = 5;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_frame_reader_if #(.DATA_W(DATA_W), .USEDW_W(USEDW_W)) bus_if ();

  fifo_frame_reader #(
    .DATA_W(DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .USEDW_W(USEDW_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;

  logic [DATA_W-1:0]  mem [0:63];
  int                 wptr = 0;
  int                 rptr = 0;
  int                 level;
  logic               push_en = 1'b0;
  logic [DATA_W-1:0]  push_val = '0;
  logic               clear_stats = 1'b0;
  logic               ready_mode = 1'b0;
  logic               rdfull_force = 1'b0;
  logic               usedw_ovr_en = 1'b0;
  logic [USEDW_W-1:0] usedw_ovr = '0;
  int                 stall_from = -100;
  logic               stall_now;
  int                 rd_issued = 0;
  int                 rd_while_empty = 0;

  int          nbeats = 0;
  logic [13:0] beat_word [0:31];
  int          beat_cyc [0:31];
  int          stab_err = 0;
  int          max_out = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_word = '0;
  logic [13:0] cur_word;

  assign level     = wptr - rptr;
  assign stall_now = (cyc >= stall_from) && (cyc < stall_from + 5);
  assign cur_word  = {bus_if.sink_sop, bus_if.sink_eop, bus_if.sink_data};

  assign bus_if.fifo_rdempty = (level == 0) || stall_now;
  assign bus_if.fifo_rdusedw = usedw_ovr_en ? usedw_ovr : USEDW_W'(level);
  assign bus_if.fifo_rdfull  = rdfull_force;
  assign bus_if.sink_ready   = ready_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;

  // FIFO model with one cycle read latency, plus cycle and read counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear_stats) begin
      rptr           <= wptr;
      rd_issued      <= 0;
      rd_while_empty <= 0;
    end else if (bus_if.fifo_rdreq) begin
      bus_if.fifo_q <= mem[rptr % 64];
      rptr          <= rptr + 1;
      rd_issued     <= rd_issued + 1;
      if (bus_if.fifo_rdempty) rd_while_empty <= rd_while_empty + 1;
    end
    if (push_en) begin
      mem[wptr % 64] <= push_val;
      wptr           <= wptr + 1;
    end
  end

  // Sink-side monitor sampling away from the active edge.
  always @(negedge clk) begin
    if (clear_stats) begin
      nbeats     = 0;
      stab_err   = 0;
      max_out    = 0;
      done_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (rd_issued - nbeats > max_out) max_out = rd_issued - nbeats;
      if (prev_stall && (!bus_if.sink_valid || cur_word != prev_word)) stab_err++;
      prev_stall = bus_if.sink_valid && !bus_if.sink_ready;
      prev_word  = cur_word;
      if (bus_if.sink_valid && bus_if.sink_ready) begin
        if (nbeats < 32) begin
          beat_word[nbeats] = cur_word;
          beat_cyc[nbeats]  = cyc;
        end
        nbeats++;
      end
      if (bus_if.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearStats();
    @(posedge clk); #1 clear_stats = 1'b1;
    @(posedge clk); #1 clear_stats = 1'b0;
  endtask

  task automatic pushData(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      push_en  = 1'b1;
      push_val = DATA_W'(base + i);
    end
    @(posedge clk); #1 push_en = 1'b0;
  endtask

  task automatic pulseReq();
    @(posedge clk); #1;
    bus_if.frame_req = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1 bus_if.frame_req = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrame(input string tag, input int base, input bit timing);
    logic [13:0] exp_word;
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_word = {(i == 0), (i == FRAME_LEN - 1), DATA_W'(base + i)};
      checkOutput($sformatf("%s_beat%0d", tag, i), 32'(beat_word[i]), 32'(exp_word));
    end
    checkOutput({tag, "_nbeats"}, nbeats, FRAME_LEN);
    checkOutput({tag, "_rdreq_total"}, rd_issued, FRAME_LEN);
    checkOutput({tag, "_rd_when_empty"}, rd_while_empty, 0);
    checkOutput({tag, "_stable"}, stab_err, 0);
    checkOutput({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_done_after_eop"}, done_cyc, beat_cyc[FRAME_LEN-1] + 1);
    checkOutput({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    if (timing) begin
      checkOutput({tag, "_first_latency"}, beat_cyc[0] - req_cyc, 4);
      checkOutput({tag, "_back_to_back"}, beat_cyc[FRAME_LEN-1] - beat_cyc[0], FRAME_LEN - 1);
    end
  endtask

  task automatic applyStimulus(input string tag, input int base, input int nload,
                               input bit bp, input bit stall, input bit extra_req,
                               input bit timing);
    clearStats();
    pushData(base, nload);
    ready_mode = bp;
    pulseReq();
    if (stall) stall_from = req_cyc + 6;
    if (extra_req) begin
      while (cyc < req_cyc + 5) begin
        @(posedge clk); #1;
      end
      bus_if.frame_req = 1'b1;
      @(posedge clk); #1 bus_if.frame_req = 1'b0;
    end
    waitDone(tag);
    checkFrame(tag, base, timing);
    stall_from = -100;
    ready_mode = 1'b0;
    if (extra_req) begin
      repeat (20) @(negedge clk);
      checkOutput({tag, "_no_second_rdreq"}, rd_issued, FRAME_LEN);
      checkOutput({tag, "_no_second_beats"}, nbeats, FRAME_LEN);
      checkOutput({tag, "_stays_idle"}, 32'(bus_if.busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    bus_if.frame_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus_if.sink_valid), 32'd0);
    checkOutput("rst_sop", 32'(bus_if.sink_sop), 32'd0);
    checkOutput("rst_eop", 32'(bus_if.sink_eop), 32'd0);
    checkOutput("rst_data", 32'(bus_if.sink_data), 32'd0);
    checkOutput("rst_rdreq", 32'(bus_if.fifo_rdreq), 32'd0);
    checkOutput("rst_done", 32'(bus_if.frame_done), 32'd0);
    rst_n = 1'b1;

    $display("[TB] normal frame");
    applyStimulus("normal", 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] fill ramp");
    clearStats();
    ready_mode = 1'b0;
    pulseReq();
    pushData(12'h080, 7);
    repeat (3) @(negedge clk);
    checkOutput("ramp_no_rdreq", rd_issued, 0);
    checkOutput("ramp_waiting_busy", 32'(bus_if.busy), 32'd1);
    pushData(12'h087, 1);
    waitDone("ramp");
    checkFrame("ramp", 12'h080, 1'b0);

    $display("[TB] rdfull with wrapped usedw");
    clearStats();
    usedw_ovr_en = 1'b1;
    usedw_ovr    = '0;
    pushData(12'h0C0, 8);
    pulseReq();
    repeat (4) @(negedge clk);
    checkOutput("wrap_no_rdreq", rd_issued, 0);
    checkOutput("wrap_waiting_busy", 32'(bus_if.busy), 32'd1);
    rdfull_force = 1'b1;
    waitDone("wrap");
    checkFrame("wrap", 12'h0C0, 1'b0);
    rdfull_force = 1'b0;
    usedw_ovr_en = 1'b0;

    $display("[TB] backpressure");
    applyStimulus("bp", 12'h140, 10, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] empty stall");
    applyStimulus("stall", 12'h1A0, 8, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] ignored request");
    applyStimulus("ignore", 12'h0E0, 16, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset mid-stream");
    clearStats();
    pushData(12'h200, 8);
    ready_mode = 1'b0;
    pulseReq();
    n = 0;
    while (nbeats < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstmid_pre_valid", 32'(bus_if.sink_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("rstmid_valid", 32'(bus_if.sink_valid), 32'd0);
    checkOutput("rstmid_sop", 32'(bus_if.sink_sop), 32'd0);
    checkOutput("rstmid_eop", 32'(bus_if.sink_eop), 32'd0);
    checkOutput("rstmid_data", 32'(bus_if.sink_data), 32'd0);
    checkOutput("rstmid_rdreq", 32'(bus_if.fifo_rdreq), 32'd0);
    checkOutput("rstmid_done", 32'(bus_if.frame_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("after_rst", 12'h300, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
